// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single shared memory port: data accesses win over
// instruction fetch, with a starvation guard for fetch and a no-ack watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 19,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic { FETCH, DATA } owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic              mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              if_done_nxt, d_done_nxt, err_nxt;
  logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;

  logic ereq_d, ereq_f, grant_f, grant_d;

  // A requester is masked in the cycle its own done pulses, so a held request
  // is not re-granted for an access that just completed.
  assign ereq_d  = d_req & ~d_done;
  assign ereq_f  = if_req & ~if_done;
  assign grant_f = ereq_f & (~ereq_d | (starve_cnt == CNT_W'(MAX_WAIT)));
  assign grant_d = ereq_d & ~grant_f;
  assign stall   = ereq_d | ereq_f;

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= FETCH;
      starve_cnt <= '0;
      timer      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
      timer      <= timer_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_done    <= if_done_nxt;
      d_done     <= d_done_nxt;
      err        <= err_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    starve_nxt    = starve_cnt;
    timer_nxt     = timer;
    mem_en_nxt    = mem_en;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_done_nxt   = 1'b0;
    d_done_nxt    = 1'b0;
    err_nxt       = 1'b0;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;

    case (state)
      IDLE: begin
        if (grant_f) begin
          owner_nxt    = FETCH;
          state_nxt    = BUSY;
          timer_nxt    = '0;
          starve_nxt   = '0;
          mem_en_nxt   = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = if_addr;
        end else if (grant_d) begin
          owner_nxt     = DATA;
          state_nxt     = BUSY;
          timer_nxt     = '0;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          // Only a contested loss counts towards forcing fetch through.
          if (ereq_f && starve_cnt != CNT_W'(MAX_WAIT))
            starve_nxt = starve_cnt + 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_nxt  = IDLE;
          mem_en_nxt = 1'b0;
          mem_we_nxt = 1'b0;
          if (owner == FETCH) begin
            if_done_nxt  = 1'b1;
            if_rdata_nxt = mem_rdata;
          end else begin
            d_done_nxt = 1'b1;
            if (!mem_we) d_rdata_nxt = mem_rdata;
          end
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_nxt  = IDLE;
          mem_en_nxt = 1'b0;
          mem_we_nxt = 1'b0;
          err_nxt    = 1'b1;
          if (owner == FETCH) if_done_nxt = 1'b1;
          else                d_done_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation guard,
// multi-wait load, watchdog timeout and reset in the middle of an access.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_done;
  logic [18:0] if_rdata;
  logic        d_req, d_we;
  logic [11:0] d_addr;
  logic [18:0] d_wdata;
  logic        d_done;
  logic [18:0] d_rdata;
  logic        err, stall, mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [18:0] mem_wdata;
  logic [18:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_fails  = 0;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(19), .MAX_WAIT(4), .TIMEOUT(16)) dut (
    .clock(clock), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; mem_rdata = '0; mem_ack = 0;
    step(); step();
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_dones", {29'd0, if_done, d_done, err}, 0);
    check("rst_if_rdata", 32'(if_rdata), 0);
    check("rst_d_rdata", 32'(d_rdata), 0);
    check("rst_stall", 32'(stall), 0);
    rst = 1'b0;
    step();

    // Single fetch against a zero-wait memory
    if_req = 1; if_addr = 12'h005; mem_ack = 1; mem_rdata = 19'h1ABCD;
    #1 check("f_stall_req", 32'(stall), 1);
    step();
    check("f_mem_en", 32'(mem_en), 1);
    check("f_mem_addr", 32'(mem_addr), 32'h005);
    check("f_mem_we", 32'(mem_we), 0);
    check("f_done_early", 32'(if_done), 0);
    step();
    check("f_if_done", 32'(if_done), 1);
    check("f_if_rdata", 32'(if_rdata), 32'h1ABCD);
    check("f_mem_en_drop", 32'(mem_en), 0);
    check("f_stall_done", 32'(stall), 0);
    if_req = 0;
    step();
    check("f_done_pulse", 32'(if_done), 0);
    check("f_stall_after", 32'(stall), 0);

    // Simultaneous store and fetch: store first, fetch right after
    d_req = 1; d_we = 1; d_addr = 12'h010; d_wdata = 19'h00042;
    if_req = 1; if_addr = 12'h006; mem_rdata = 19'h07777;
    step();
    check("s_mem_we", 32'(mem_we), 1);
    check("s_mem_addr", 32'(mem_addr), 32'h010);
    check("s_mem_wdata", 32'(mem_wdata), 32'h00042);
    step();
    check("s_d_done", {30'd0, d_done, if_done}, 32'b10);
    check("s_d_rdata", 32'(d_rdata), 0);
    d_req = 0;
    step();
    check("s_f_grant", {19'd0, mem_en, mem_we, mem_addr}, {19'd0, 1'b1, 1'b0, 12'h006});
    check("s_d_done_pulse", 32'(d_done), 0);
    check("s_starve_clr", 32'(dut.starve_cnt), 0);
    step();
    check("s_if_done", {30'd0, d_done, if_done}, 32'b01);
    check("s_if_rdata", 32'(if_rdata), 32'h07777);
    if_req = 0;
    step();

    // Starvation guard: four contested data wins, then fetch is forced through
    for (int k = 0; k < 4; k++) begin
      d_req = 1; d_we = 1; d_addr = 12'(32'h020 + k); d_wdata = 19'(32'h100 + k);
      if_req = 1; if_addr = 12'h007;
      step();
      check("sv_data_grant", {19'd0, mem_we, mem_addr}, {19'd0, 1'b1, 12'(32'h020 + k)});
      step();
      check("sv_d_done", 32'(d_done), 1);
      if_req = 0;
      step();
    end
    check("sv_cnt_max", 32'(dut.starve_cnt), 4);
    if_req = 1; mem_rdata = 19'h15555;
    step();
    check("sv_fetch_forced", {19'd0, mem_we, mem_addr}, {19'd0, 1'b0, 12'h007});
    check("sv_cnt_clr", 32'(dut.starve_cnt), 0);
    d_req = 0;
    step();
    check("sv_if_done", 32'(if_done), 1);
    check("sv_if_rdata", 32'(if_rdata), 32'h15555);
    if_req = 0;
    step();

    // Load with three wait cycles
    mem_ack = 0; d_req = 1; d_we = 0; d_addr = 12'h123; mem_rdata = 19'h2AAAA;
    step();
    for (int k = 0; k < 3; k++) begin
      check("mw_hold", {18'd0, mem_en, stall, mem_addr}, {18'd0, 1'b1, 1'b1, 12'h123});
      check("mw_no_done", 32'(d_done), 0);
      if (k < 2) step();
    end
    mem_ack = 1; mem_rdata = 19'h3C3C3;
    step();
    check("mw_d_done", 32'(d_done), 1);
    check("mw_d_rdata", 32'(d_rdata), 32'h3C3C3);
    check("mw_stall", 32'(stall), 0);
    d_req = 0; mem_ack = 0;
    step();

    // Watchdog: no ack ever
    d_req = 1; d_we = 0; d_addr = 12'h0AB; mem_rdata = 19'h11111;
    step();
    for (int k = 0; k < 15; k++) begin
      step();
      check("to_busy", {30'd0, mem_en, d_done}, 32'b10);
    end
    step();
    check("to_done_err", {29'd0, d_done, err, mem_en}, 32'b110);
    check("to_d_rdata", 32'(d_rdata), 32'h3C3C3);
    d_req = 0;
    step();
    check("to_pulse", {30'd0, d_done, err}, 0);

    // Reset two cycles into a long access; a late ack must be ignored
    d_req = 1; d_we = 0; d_addr = 12'h055;
    step(); step(); step();
    rst = 1;
    step();
    check("rb_mem_en", 32'(mem_en), 0);
    check("rb_mem_addr", 32'(mem_addr), 0);
    check("rb_dones", {29'd0, d_done, if_done, err}, 0);
    check("rb_d_rdata", 32'(d_rdata), 0);
    rst = 0; d_req = 0; mem_ack = 1; mem_rdata = 19'h7FFFF;
    step();
    check("rb_late_ack", {29'd0, mem_en, d_done, if_done}, 0);
    check("rb_late_rdata", 32'(d_rdata), 0);
    mem_ack = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the processor's single shared memory port. The instruction-fetch path and the data path (LDM/STM) each raise a request. The block serialises them onto one handshaked memory interface, returns read data, and drives a stall flag. The core's PC-enable logic uses that flag to freeze instruction flow until pending accesses complete. Data accesses take priority, with a starvation guard for fetch and a watchdog for memories that never respond.

## Interface
- ADDR_W, 12, address width of both requesters and the memory
- DATA_W, 19, data word width
- MAX_WAIT, 4, consecutive contested arbitrations fetch may lose before it is forced to win
- TIMEOUT, 16, BUSY cycles without mem_ack before the transaction is aborted
- clock  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse: fetch finished
- if_rdata  out  DATA_W  fetched word; held until next fetch completion
- d_req  in  1  data request (LDM or STM); held until d_done
- d_we  in  1  1 = store (STM), 0 = load (LDM)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data access finished
- d_rdata  out  DATA_W  load result; held until next load completion
- err  out  1  one-cycle pulse coincident with a done that ended by timeout
- stall  out  1  combinational: a request is pending and not completing this cycle
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable; valid while mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack
- mem_ack  in  1  memory completion; sampled only in BUSY

## Operation
- FSM states: IDLE and BUSY. A registered owner bit selects FETCH or DATA.
- **IDLE:**
  - Effective requests: ereq_d = d_req & ~d_done, ereq_f = if_req & ~if_done. A request is masked in the cycle its own done pulses.
  - Grant rule: fetch wins if only ereq_f is set, or if both are set and starve_cnt == MAX_WAIT. Otherwise data wins when ereq_d is set.
  - On grant: latch address, we (0 for fetch), and wdata into mem_* registers; set mem_en=1; go to BUSY.
  - starve_cnt increments, saturating at MAX_WAIT, when both are set and data wins. It clears when fetch is granted.
- **BUSY:**
  - mem_en, mem_we, mem_addr and mem_wdata are held constant. Requester inputs are ignored.
  - timer increments each BUSY cycle.
- **On mem_ack in BUSY:**
  - Drop mem_en and mem_we; go to IDLE; pulse the owner's done.
  - If the access was a read, register mem_rdata into the owner's rdata.
  - A store leaves d_rdata unchanged.
- **On timer == TIMEOUT-1 without mem_ack:**
  - Go to IDLE; pulse the owner's done together with err.
  - rdata is unchanged.
- mem_ack outside BUSY is ignored.
- stall = ereq_d | ereq_f.
- A requester that deasserts req mid-transaction does not abort it; done still pulses.

## Timing
- **Reset** (the cycle after rst is sampled high):
  - state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_done=0, d_done=0, err=0, if_rdata=0, d_rdata=0, starve_cnt=0, timer=0.
  - An in-flight transaction is dropped with no done.
- **Latency:**
  - Request seen in IDLE at edge N gives mem_en=1 after edge N.
  - mem_ack sampled at edge M gives done=1 after edge M.
  - Minimum per transaction with zero-wait memory: 2 cycles. Back-to-back grants are possible because IDLE grants in the same cycle done pulses.
- **Simultaneous requests:** d_req and if_req rising together give data first, then fetch on the next IDLE cycle.
- **Timeout:** done+err after exactly TIMEOUT BUSY cycles.
- **Done pulses:** exactly one cycle, never both done signals in the same cycle.

## Test plan
- **Single fetch, zero-wait memory:** if_req=1, if_addr=0x005, mem_ack same cycle as mem_en, mem_rdata=0x1ABCD → mem_addr=0x005, mem_we=0, if_done pulses 2 cycles after request, if_rdata=0x1ABCD, stall low afterward.
- **Simultaneous requests:** d_req (store, addr 0x010, wdata 0x00042) and if_req (0x006) → store granted first with mem_we=1, d_done pulses, then fetch granted with no idle gap; d_rdata unchanged.
- **Starvation guard:** hold if_req and re-raise d_req after every d_done, MAX_WAIT=4 → exactly 4 data grants, then a fetch grant; starve_cnt returns to 0.
- **Timeout:** d_req load, mem_ack never asserted → d_done and err pulse together after 16 BUSY cycles, mem_en drops, d_rdata holds its previous value.
- **Reset mid-BUSY:** assert rst 2 cycles into a 5-cycle memory access → next cycle mem_en=0, no done pulse, all outputs at reset values; a late mem_ack is ignored.
- **Multi-wait load:** mem_ack after 3 cycles → mem_addr and mem_en stable throughout, stall=1 until d_done, d_rdata captured exactly at ack.
